// File: rtl/cordic_vector.sv
// cordic_vector -- iterative vectoring-mode CORDIC computing atan2(y, x) and
// the gain-compensated magnitude sqrt(x^2 + y^2) of a signed 32-bit vector.
//
// One micro-rotation is done per clock. After the accepting edge there are
// ITER iteration edges, then one scaling edge. So a result takes ITER+2
// cycles, and a new request can be accepted in the cycle that done is high.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request, sampled only while idle
//   x_in/y_in  signed 32-bit coordinates (any common fixed-point scale)
//   angle_out  atan2(y, x) in radians, Q3.29, range [-pi, +pi]
//   mag_out    magnitude in input scale, saturated to 2^31-1, never negative
//   busy       high while an operation is in flight
//   done       one-cycle pulse; outputs are valid from that cycle until the
//              next done
module cordic_vector #(
    parameter int ITER = 30             // micro-rotations, legal 16..30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    output logic signed [31:0] angle_out,
    output logic signed [31:0] mag_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SCALE
    } state_t;

    localparam logic [4:0]         LAST_IDX = 5'(ITER - 1);
    localparam logic signed [33:0] HALF_PI  = 34'sd843314857;    // pi/2, Q3.29
    localparam logic signed [65:0] INV_K    = 66'sd652032874;    // 1/K, Q1.30
    localparam logic signed [65:0] RND_HALF = 66'sd536870912;    // 2^29
    localparam logic signed [65:0] MAG_MAX  = 66'sd2147483647;

    state_t             state;
    state_t             state_nxt;
    logic [4:0]         iter_idx;

    // 35-bit x/y leave headroom for sqrt(2) * 2^31 * K (about 5e9).
    logic signed [34:0] x_r;
    logic signed [34:0] y_r;
    logic signed [33:0] z_r;
    logic               zero_in;        // captured vector was (0, 0)

    logic signed [34:0] x_ext;
    logic signed [34:0] y_ext;
    logic signed [34:0] x_sh;
    logic signed [34:0] y_sh;
    logic signed [33:0] atan_i;
    logic signed [65:0] prod;
    logic signed [65:0] mag_full;
    logic signed [31:0] mag_sat;

    // atan(2^-i) in Q3.29, rounded to nearest.
    function automatic logic signed [33:0] atan_lut(input logic [4:0] idx);
        logic signed [33:0] v;
        case (idx)
            5'd0:    v = 34'sd421657428;
            5'd1:    v = 34'sd248918915;
            5'd2:    v = 34'sd131521918;
            5'd3:    v = 34'sd66762579;
            5'd4:    v = 34'sd33510843;
            5'd5:    v = 34'sd16771758;
            5'd6:    v = 34'sd8387925;
            5'd7:    v = 34'sd4194219;
            5'd8:    v = 34'sd2097141;
            5'd9:    v = 34'sd1048575;
            5'd10:   v = 34'sd524288;
            5'd11:   v = 34'sd262144;
            5'd12:   v = 34'sd131072;
            5'd13:   v = 34'sd65536;
            5'd14:   v = 34'sd32768;
            5'd15:   v = 34'sd16384;
            5'd16:   v = 34'sd8192;
            5'd17:   v = 34'sd4096;
            5'd18:   v = 34'sd2048;
            5'd19:   v = 34'sd1024;
            5'd20:   v = 34'sd512;
            5'd21:   v = 34'sd256;
            5'd22:   v = 34'sd128;
            5'd23:   v = 34'sd64;
            5'd24:   v = 34'sd32;
            5'd25:   v = 34'sd16;
            5'd26:   v = 34'sd8;
            5'd27:   v = 34'sd4;
            5'd28:   v = 34'sd2;
            5'd29:   v = 34'sd1;
            default: v = 34'sd0;
        endcase
        return v;
    endfunction

    assign x_ext  = {{3{x_in[31]}}, x_in};
    assign y_ext  = {{3{y_in[31]}}, y_in};
    assign x_sh   = x_r >>> iter_idx;
    assign y_sh   = y_r >>> iter_idx;
    assign atan_i = atan_lut(iter_idx);

    // Gain compensation: round((x * 1/K) >>> 30), clamped to [0, 2^31-1].
    assign prod     = {{31{x_r[34]}}, x_r} * INV_K;
    assign mag_full = (prod + RND_HALF) >>> 30;

    always_comb begin
        mag_sat = mag_full[31:0];
        if (mag_full > MAG_MAX)
            mag_sat = 32'sh7fff_ffff;
        else if (mag_full < 0)
            mag_sat = 32'sd0;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ITER;
            S_ITER:  if (iter_idx == LAST_IDX) state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            iter_idx  <= '0;
            zero_in   <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Fold the left half-plane into the right half so the
                        // micro-rotations only need to cover +/- ~99 degrees.
                        if (!x_in[31]) begin
                            x_r <= x_ext;
                            y_r <= y_ext;
                            z_r <= '0;
                        end else if (!y_in[31]) begin
                            x_r <= y_ext;
                            y_r <= -x_ext;
                            z_r <= HALF_PI;
                        end else begin
                            x_r <= -y_ext;
                            y_r <= x_ext;
                            z_r <= -HALF_PI;
                        end
                        // (0,0) would otherwise accumulate the whole atan
                        // table as y never goes negative.
                        zero_in  <= (x_in == 32'sd0) && (y_in == 32'sd0);
                        iter_idx <= '0;
                        busy     <= 1'b1;
                    end
                end
                S_ITER: begin
                    // Rotate toward the x axis: y < 0 rotates counter-clockwise.
                    if (y_r[34]) begin
                        x_r <= x_r - y_sh;
                        y_r <= y_r + x_sh;
                        z_r <= z_r - atan_i;
                    end else begin
                        x_r <= x_r + y_sh;
                        y_r <= y_r - x_sh;
                        z_r <= z_r + atan_i;
                    end
                    iter_idx <= iter_idx + 5'd1;
                end
                S_SCALE: begin
                    mag_out   <= mag_sat;
                    angle_out <= zero_in ? 32'sd0 : z_r[31:0];
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
